// File: rtl/dump_sm.sv
// dump_sm: reads one capture-RAM channel from the trigger position onward and feeds each byte to the UART
module dump_sm #(
    parameter int ENTRIES = 384,
    parameter int AW = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          dump_req,
    input  logic [1:0]    dump_chan,
    input  logic [AW-1:0] trig_pos,
    input  logic [7:0]    read_data,
    input  logic          tx_done,
    output logic          dump_en,
    output logic [1:0]    ch_sel,
    output logic [AW-1:0] addr,
    output logic [7:0]    tx_data,
    output logic          tx_start,
    output logic          busy,
    output logic          dump_done,
    output logic          req_err
);
    localparam int W1 = AW + 1;
    localparam logic [AW:0] LAST = W1'(ENTRIES - 1);

    typedef enum logic [1:0] {IDLE, RD, LD, TX} state_t;

    state_t        state, state_n;
    logic [AW:0]   cnt, cnt_n;
    logic [1:0]    ch_sel_n;
    logic [AW-1:0] addr_n;
    logic [7:0]    tx_data_n;
    logic          tx_start_n, busy_n, dump_done_n, req_err_n;

    assign dump_en = state == RD;

    // state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            ch_sel    <= '0;
            addr      <= '0;
            tx_data   <= '0;
            tx_start  <= 1'b0;
            busy      <= 1'b0;
            dump_done <= 1'b0;
            req_err   <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            ch_sel    <= ch_sel_n;
            addr      <= addr_n;
            tx_data   <= tx_data_n;
            tx_start  <= tx_start_n;
            busy      <= busy_n;
            dump_done <= dump_done_n;
            req_err   <= req_err_n;
        end
    end

    // next state: accept request, read, load byte, wait for UART, advance with wrap
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        ch_sel_n    = ch_sel;
        addr_n      = addr;
        tx_data_n   = tx_data;
        tx_start_n  = 1'b0;
        busy_n      = busy;
        dump_done_n = 1'b0;
        req_err_n   = 1'b0;
        case (state)
            IDLE: if (dump_req) begin
                if (dump_chan == 2'b11) begin
                    req_err_n = 1'b1;
                end else begin
                    ch_sel_n = dump_chan;
                    addr_n   = ({1'b0, trig_pos} <= LAST) ? trig_pos : '0;
                    cnt_n    = '0;
                    busy_n   = 1'b1;
                    state_n  = RD;
                end
            end
            RD: state_n = LD;
            LD: begin
                tx_data_n  = read_data;
                tx_start_n = 1'b1;
                state_n    = TX;
            end
            default: if (tx_done) begin
                if (cnt == LAST) begin
                    busy_n      = 1'b0;
                    dump_done_n = 1'b1;
                    state_n     = IDLE;
                end else begin
                    cnt_n   = cnt + 1'b1;
                    addr_n  = (addr == LAST[AW-1:0]) ? '0 : addr + 1'b1;
                    state_n = RD;
                end
            end
        endcase
    end
endmodule

// File: tb/tb_dump_sm.sv
// tb_dump_sm: directed bench for dump_sm with RAM/UART models and an address/data scoreboard
module tb_dump_sm;
    localparam int ENTRIES = 4;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          dump_req = 1'b0;
    logic [1:0]    dump_chan = '0;
    logic [AW-1:0] trig_pos = '0;
    logic [7:0]    read_data = '0;
    logic          tx_done = 1'b0;
    logic          dump_en, tx_start, busy, dump_done, req_err;
    logic [1:0]    ch_sel;
    logic [AW-1:0] addr;
    logic [7:0]    tx_data;

    logic [7:0]    mem [0:3][0:3];
    logic [AW-1:0] addr_q [$];
    logic [7:0]    data_q [$];
    int            n_tests = 0, n_fail = 0;
    int            n_start = 0, n_done = 0, n_err = 0;
    int            cd = 0, uart_dly = 4;
    bit            uart_auto = 1'b1;
    logic [1:0]    exp_ch = '0;
    int            s0, d0, e0;

    dump_sm #(.ENTRIES(ENTRIES), .AW(AW)) dut (
        .clk(clk), .rst(rst), .dump_req(dump_req), .dump_chan(dump_chan),
        .trig_pos(trig_pos), .read_data(read_data), .tx_done(tx_done),
        .dump_en(dump_en), .ch_sel(ch_sel), .addr(addr), .tx_data(tx_data),
        .tx_start(tx_start), .busy(busy), .dump_done(dump_done), .req_err(req_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (dump_en) read_data <= mem[ch_sel][addr[1:0]];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
        tx_done = 1'b0;
        if (uart_auto && cd > 0) begin
            cd--;
            if (cd == 0) tx_done = 1'b1;
        end
        if (dump_en) begin
            check("addr_q_nonempty", 32'(addr_q.size() != 0), 1);
            if (addr_q.size() != 0) check("rd_addr", 32'(addr), 32'(addr_q.pop_front()));
        end
        if (tx_start) begin
            n_start++;
            check("data_q_nonempty", 32'(data_q.size() != 0), 1);
            if (data_q.size() != 0) check("tx_data", 32'(tx_data), 32'(data_q.pop_front()));
            check("proto_done_with_start", 32'(tx_done), 0);
            if (uart_auto) cd = uart_dly;
        end
        if (busy) check("ch_sel", 32'(ch_sel), 32'(exp_ch));
        if (dump_done) n_done++;
        if (req_err) n_err++;
    endtask

    task automatic start_dump(input logic [1:0] ch, input logic [AW-1:0] tp);
        int st;
        st = (tp < ENTRIES) ? int'(tp) : 0;
        for (int i = 0; i < ENTRIES; i++) begin
            addr_q.push_back(AW'((st + i) % ENTRIES));
            data_q.push_back(mem[ch][(st + i) % ENTRIES]);
        end
        exp_ch = ch;
        dump_req = 1'b1;
        dump_chan = ch;
        trig_pos = tp;
        step;
        dump_req = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while (!dump_done && k < budget) begin
            step;
            k++;
        end
        check("dump_done_seen", 32'(dump_done), 1);
        check("busy_low_at_done", 32'(busy), 0);
    endtask

    task automatic check_reset;
        check("rst_ch_sel", 32'(ch_sel), 0);
        check("rst_addr", 32'(addr), 0);
        check("rst_tx_data", 32'(tx_data), 0);
        check("rst_dump_en", 32'(dump_en), 0);
        check("rst_tx_start", 32'(tx_start), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_dump_done", 32'(dump_done), 0);
        check("rst_req_err", 32'(req_err), 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4; i++) begin
            mem[0][i] = 8'h10 + 8'(i);
            mem[1][i] = 8'hA0 + 8'(i);
            mem[2][i] = 8'hC0 + 8'(i);
            mem[3][i] = 8'hEE;
        end
        step;
        step;
        check_reset;
        rst = 1'b0;
        step;

        s0 = n_start; d0 = n_done;
        start_dump(2'b01, 3'd0);
        check("basic_en_c1", 32'(dump_en), 1);
        check("basic_addr_c1", 32'(addr), 0);
        check("basic_busy", 32'(busy), 1);
        step;
        check("basic_en_c2", 32'(dump_en), 0);
        check("basic_start_c2", 32'(tx_start), 0);
        step;
        check("basic_start_c3", 32'(tx_start), 1);
        check("basic_data_c3", 32'(tx_data), 32'h A0);
        wait_done(100);
        check("basic_bytes", 32'(n_start - s0), 4);
        check("basic_dones", 32'(n_done - d0), 1);
        check("basic_q_empty", 32'(addr_q.size() + data_q.size()), 0);
        step;
        check("done_one_cycle", 32'(dump_done), 0);

        s0 = n_start; d0 = n_done;
        start_dump(2'b00, 3'd2);
        check("wrap_first_addr", 32'(addr), 2);
        wait_done(100);
        check("wrap_bytes", 32'(n_start - s0), 4);
        check("wrap_dones", 32'(n_done - d0), 1);
        check("wrap_q_empty", 32'(addr_q.size() + data_q.size()), 0);
        step;

        e0 = n_err;
        dump_req = 1'b1; dump_chan = 2'b11; trig_pos = 3'd0;
        step;
        dump_req = 1'b0;
        check("inv_req_err", 32'(req_err), 1);
        check("inv_busy", 32'(busy), 0);
        check("inv_dump_en", 32'(dump_en), 0);
        check("inv_tx_start", 32'(tx_start), 0);
        step;
        check("inv_err_one_cycle", 32'(req_err), 0);
        check("inv_still_idle", 32'(busy | dump_en | tx_start), 0);
        check("inv_err_count", 32'(n_err - e0), 1);

        uart_dly = 6;
        s0 = n_start; e0 = n_err;
        start_dump(2'b10, 3'd1);
        repeat (4) step;
        dump_req = 1'b1; dump_chan = 2'b00; trig_pos = 3'd0;
        step;
        dump_req = 1'b0;
        check("busyreq_no_err", 32'(req_err), 0);
        wait_done(100);
        check("busyreq_bytes", 32'(n_start - s0), 4);
        check("busyreq_err_count", 32'(n_err - e0), 0);
        check("busyreq_q_empty", 32'(addr_q.size() + data_q.size()), 0);
        s0 = n_start;
        start_dump(2'b01, 3'd3);
        check("b2b_busy", 32'(busy), 1);
        check("b2b_en", 32'(dump_en), 1);
        check("b2b_addr", 32'(addr), 3);
        wait_done(100);
        check("b2b_bytes", 32'(n_start - s0), 4);
        check("b2b_q_empty", 32'(addr_q.size() + data_q.size()), 0);
        step;

        uart_auto = 1'b0; cd = 0;
        start_dump(2'b10, 3'd5);
        check("lat_en_c1", 32'(dump_en), 1);
        check("lat_oob_addr", 32'(addr), 0);
        step;
        step;
        check("lat_start_c3", 32'(tx_start), 1);
        check("lat_data_c3", 32'(tx_data), 32'h C0);
        repeat (7) step;
        check("lat_wait_tx", 32'({busy, dump_en, tx_start}), 32'b100);
        tx_done = 1'b1;
        step;
        check("lat_en_c11", 32'(dump_en), 1);
        check("lat_addr_c11", 32'(addr), 1);
        step;
        step;
        check("lat_start_c13", 32'(tx_start), 1);
        check("lat_data_c13", 32'(tx_data), 32'h C1);
        step;
        rst = 1'b1;
        step;
        rst = 1'b0;
        check_reset;
        addr_q.delete();
        data_q.delete();
        s0 = n_start; d0 = n_done;
        tx_done = 1'b1;
        step;
        repeat (5) step;
        check("post_rst_no_start", 32'(n_start - s0), 0);
        check("post_rst_no_done", 32'(n_done - d0), 0);
        check("post_rst_idle", 32'(busy | dump_en), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
